serial_word_assembler: RTL and testbench
========================================

// Module: serial_word_assembler
// PURPOSE
//  Downstream consumer of the 8-bit LFSR pattern generator's serial output (OUT/Valid, LSB first).
//  Rebuilds DATA_WIDTH-bit words from the serial stream and presents them on a
//  valid/ready parallel interface. Flags frames that stall mid-word (gap timeout)
//  and words lost because the consumer did not accept the previous one (overrun).
// PARAMETERS
//  DATA_WIDTH      8   bits per assembled word (>=2)
//  TIMEOUT_CYCLES  16  max consecutive Ser_Valid-low cycles inside a frame; 0 disables timeout
//  CNT_W           localparam, $clog2(DATA_WIDTH+1), bit counter width
//  GAP_W           localparam, $clog2(TIMEOUT_CYCLES+1) (min 1), gap counter width
// PORTS
//  Clock        in   1           rising-edge clock
//  Reset        in   1           asynchronous, active-low reset
//  Clear        in   1           synchronous abort: drop partial word and held output
//  Ser_In       in   1           serial data bit, sampled when Ser_Valid=1
//  Ser_Valid    in   1           serial bit qualifier
//  Data_Out     out  DATA_WIDTH  assembled word, first-received bit at [0]
//  Data_Valid   out  1           Data_Out holds an unaccepted word
//  Data_Ready   in   1           consumer accepts when Data_Valid&Data_Ready
//  Busy         out  1           1 while a frame is partially received (state SHIFT)
//  Frame_Error  out  1           1-cycle pulse: partial frame dropped on gap timeout
//  Overrun      out  1           1-cycle pulse: completed word dropped, output still full
// BEHAVIOUR
//  Reset (Reset=0, async): state IDLE, shift reg/bit cnt/gap cnt =0, all outputs 0.
//  Clear=1 (sync, overrides everything else): next cycle IDLE, counters 0, Data_Valid=0,
//   Data_Out unchanged, no Frame_Error/Overrun pulse; Ser_In that cycle ignored.
//  Shift: each Ser_Valid=1 cycle, sh <= {Ser_In, sh[W-1:1]}; cnt <= cnt+1.
//  FSM:
//   IDLE : Ser_Valid=1 -> capture bit, cnt=1, -> SHIFT. Ser_Valid=0 -> stay.
//   SHIFT: Ser_Valid=1 -> capture, gap=0. On capture of bit DATA_WIDTH -> word complete,
//          cnt=0, -> IDLE. Ser_Valid=0 -> gap+1; gap reaching TIMEOUT_CYCLES ->
//          Frame_Error pulse, partial discarded, cnt=0, gap=0, -> IDLE.
//  Word complete (cycle N = cycle of last bit):
//   - slot free (Data_Valid=0) or freed this cycle (Data_Valid&Data_Ready):
//     Data_Out = full word, Data_Valid=1 from cycle N+1 (latency 1 after last bit).
//   - otherwise: word discarded, Overrun=1 in cycle N+1, held word/Data_Valid untouched.
//  Output handshake: Data_Out/Data_Valid stable while Data_Valid&!Data_Ready;
//   accept drops Data_Valid next cycle unless a new word loads the same edge
//   (back-to-back: Data_Valid stays 1, Data_Out updates). Data_Out keeps last value
//   after accept.
//  Frame_Error and Overrun never both assert in the same cycle; both are registered.
//  DATA_WIDTH=1 frames impossible (param check); 8 bits at 1 bit/cycle -> 1 word / 8 cycles.
//  Continuous Ser_Valid across word boundary: bit after completion starts a new frame
//   (IDLE -> SHIFT in the following cycle, no bit lost).
//  Busy = (state==SHIFT).
// STRUCTURE
//  Shared package/header lfsr_link_pkg: state encoding (ST_IDLE=1'b0, ST_SHIFT=1'b1),
//   default DATA_WIDTH=8, default TIMEOUT_CYCLES=16.
//  One sub-module: serial_gap_timer (GAP_W counter, inputs run/kick/clear,
//   output expired pulse) instantiated once; rest is flat in this module.
// TESTING
//  1 Reset: Reset=0 mid-frame after 3 bits -> all outputs 0 immediately; next frame
//    0xA5 (bits 1,0,1,0,0,1,0,1) -> Data_Out=8'hA5, Data_Valid=1 one cycle after bit 8.
//  2 Back-to-back: Data_Ready=1, 16 continuous bits for 0x3C then 0xC3 ->
//    two Data_Valid cycles 8 cycles apart, values 8'h3C, 8'hC3, no Overrun.
//  3 Backpressure: Data_Ready=0, send 0x11 then 0x22 -> Data_Out stays 8'h11,
//    Overrun pulse one cycle after 0x22's last bit; raise Ready -> 8'h11 accepted.
//  4 Ready on completion edge: hold 0x55, assert Data_Ready in last-bit cycle of 0xAA
//    -> Data_Valid stays 1, Data_Out=8'hAA next cycle, no Overrun.
//  5 Timeout: 5 bits then Ser_Valid=0 for 16 cycles -> Frame_Error pulse, Busy=0;
//    15-cycle gap then 3 bits -> word completes, no error.
//  6 Clear: Clear=1 after 4 bits with word 0x77 held -> Data_Valid=0, Busy=0, no pulses;
//    next 8 bits 0x0F -> Data_Out=8'h0F.

Source files
------------

// File: rtl/lfsr_link_pkg.sv
// Shared definitions for the LFSR serial link: state encoding, default sizing
// and the gap-counter width helper.
package lfsr_link_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } link_state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    // Counter width that holds 0..timeout, never narrower than one bit.
    function automatic int unsigned gap_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/serial_gap_timer.sv
// Counts consecutive idle cycles inside a frame and flags the cycle in which
// the idle run reaches TIMEOUT_CYCLES. A timeout of 0 never expires.
module serial_gap_timer
    import lfsr_link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic run,
    input  logic kick,
    input  logic clear,
    output logic expired_c
);

    localparam int unsigned GAP_W = gap_width(TIMEOUT_CYCLES);

    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign expired_c = 1'b0;
        end else begin : g_timeout
            // Expires on the idle cycle that brings the count up to the limit.
            assign expired_c = run && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

    always_comb begin
        gap_d = gap_q;
        if (clear || kick || expired_c) begin
            gap_d = '0;
        end else if (run) begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/serial_word_assembler.sv
// Rebuilds LSB-first serial words into parallel words on a valid/ready port,
// reporting mid-frame gap timeouts and words lost to a full output slot.
module serial_word_assembler
    import lfsr_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Clear,
    input  logic                  Ser_In,
    input  logic                  Ser_Valid,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Data_Valid,
    input  logic                  Data_Ready,
    output logic                  Busy,
    output logic                  Frame_Error,
    output logic                  Overrun
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    generate
        if (DATA_WIDTH < 2) begin : g_bad_width
            $error("serial_word_assembler: DATA_WIDTH must be at least 2");
        end
    endgenerate

    link_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  dvalid_q, dvalid_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;

    logic [DATA_WIDTH-1:0] shifted;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  gap_run;
    logic                  gap_expired_c;

    assign shifted = {Ser_In, sh_q[DATA_WIDTH-1:1]};
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign gap_run = (state_q == ST_SHIFT) && !Ser_Valid && !Clear;

    serial_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .run      (gap_run),
        .kick     (Ser_Valid),
        .clear    (Clear),
        .expired_c(gap_expired_c)
    );

    // Next-state, shift/assembly and output-slot control.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        dvalid_d = dvalid_q && !Data_Ready;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        if (Clear) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            dvalid_d = 1'b0;
        end else if (Ser_Valid) begin
            sh_d = shifted;
            if (cnt_inc == CNT_W'(DATA_WIDTH)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                // The slot is usable if empty or being accepted on this edge.
                if (!dvalid_q || Data_Ready) begin
                    data_d   = shifted;
                    dvalid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                state_d = ST_SHIFT;
                cnt_d   = cnt_inc;
            end
        end else if ((state_q == ST_SHIFT) && gap_expired_c) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ferr_d  = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            dvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign Data_Out    = data_q;
    assign Data_Valid  = dvalid_q;
    assign Busy        = (state_q == ST_SHIFT);
    assign Frame_Error = ferr_q;
    assign Overrun     = ovr_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Testbench for serial_word_assembler: directed corner cases, a vector table
// and a randomized phase, all compared against a queue-based reference model.
module tb_serial_word_assembler;

    localparam int unsigned W = 8;
    localparam int unsigned T = 16;

    logic         Clock;
    logic         Reset;
    logic         Clear;
    logic         Ser_In;
    logic         Ser_Valid;
    logic [W-1:0] Data_Out;
    logic         Data_Valid;
    logic         Data_Ready;
    logic         Busy;
    logic         Frame_Error;
    logic         Overrun;

    int checks   = 0;
    int failures = 0;

    serial_word_assembler #(
        .DATA_WIDTH    (W),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Clear      (Clear),
        .Ser_In     (Ser_In),
        .Ser_Valid  (Ser_Valid),
        .Data_Out   (Data_Out),
        .Data_Valid (Data_Valid),
        .Data_Ready (Data_Ready),
        .Busy       (Busy),
        .Frame_Error(Frame_Error),
        .Overrun    (Overrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: the partial frame is a bit queue, the output a one-entry slot.
    bit           mq[$];
    int           mgap;
    logic [W-1:0] m_out;
    logic         m_valid;
    logic         m_fe;
    logic         m_ov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mgap    = 0;
        m_out   = '0;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic model_edge();
        logic         was_valid;
        logic         acc;
        logic [W-1:0] word;
        was_valid = m_valid;
        acc       = m_valid && Data_Ready;
        m_fe      = 1'b0;
        m_ov      = 1'b0;
        if (Clear) begin
            mq.delete();
            mgap    = 0;
            m_valid = 1'b0;
        end else begin
            if (acc) m_valid = 1'b0;
            if (Ser_Valid) begin
                mq.push_back(Ser_In);
                mgap = 0;
                if (mq.size() == W) begin
                    word = '0;
                    foreach (mq[i]) word[i] = mq[i];
                    mq.delete();
                    if (!was_valid || acc) begin
                        m_out   = word;
                        m_valid = 1'b1;
                    end else begin
                        m_ov = 1'b1;
                    end
                end
            end else if (mq.size() != 0) begin
                mgap++;
                if (mgap == T) begin
                    m_fe = 1'b1;
                    mq.delete();
                    mgap = 0;
                end
            end
        end
    endtask

    // One clock: advance the model at the edge, compare everything just after it.
    task automatic tick();
        logic busy_exp;
        @(posedge Clock);
        model_edge();
        #1;
        busy_exp = (mq.size() != 0);
        check("model", {20'h0, Data_Out, Data_Valid, Busy, Frame_Error, Overrun},
              {20'h0, m_out, m_valid, busy_exp, m_fe, m_ov});
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            Ser_Valid = 1'b1;
            Ser_In    = w[i];
            tick();
        end
        Ser_Valid = 1'b0;
        Ser_In    = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_bits(w, 0, W - 1);
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic         ready;
        logic [W-1:0] exp_out;
        logic         exp_valid;
        logic         exp_ovr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int gap_left;

        Reset      = 1'b0;
        Clear      = 1'b0;
        Ser_In     = 1'b0;
        Ser_Valid  = 1'b0;
        Data_Ready = 1'b0;
        model_reset();
        #2;
        check("reset_data",  32'(Data_Out),    32'h0);
        check("reset_valid", 32'(Data_Valid),  32'h0);
        check("reset_busy",  32'(Busy),        32'h0);
        check("reset_ferr",  32'(Frame_Error), 32'h0);
        check("reset_ovr",   32'(Overrun),     32'h0);
        #10 Reset = 1'b1;
        tick();

        // Asynchronous reset in the middle of a frame.
        send_bits(8'hFF, 0, 2);
        check("pre_reset_busy", 32'(Busy), 32'h1);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check("async_busy",  32'(Busy),       32'h0);
        check("async_valid", 32'(Data_Valid), 32'h0);
        check("async_data",  32'(Data_Out),   32'h0);
        #2 Reset = 1'b1;
        send_word(8'hA5);
        check("a5_data",  32'(Data_Out),   32'hA5);
        check("a5_valid", 32'(Data_Valid), 32'h1);

        // Back-to-back words with the consumer always ready.
        Data_Ready = 1'b1;
        tick();
        send_word(8'h3C);
        check("b2b_first",      32'(Data_Out),   32'h3C);
        check("b2b_first_v",    32'(Data_Valid), 32'h1);
        send_word(8'hC3);
        check("b2b_second",     32'(Data_Out),   32'hC3);
        check("b2b_second_v",   32'(Data_Valid), 32'h1);
        check("b2b_no_overrun", 32'(Overrun),    32'h0);
        tick();

        // Backpressure: second word is lost, first is kept.
        Data_Ready = 1'b0;
        send_word(8'h11);
        check("bp_first", 32'(Data_Out), 32'h11);
        send_word(8'h22);
        check("bp_hold",    32'(Data_Out), 32'h11);
        check("bp_overrun", 32'(Overrun),  32'h1);
        tick();
        check("bp_pulse_end", 32'(Overrun), 32'h0);
        Data_Ready = 1'b1;
        tick();
        check("bp_accepted", 32'(Data_Valid), 32'h0);
        check("bp_keep_data", 32'(Data_Out), 32'h11);

        // Ready raised in the same cycle as the last bit of the next word.
        tick();
        Data_Ready = 1'b0;
        send_word(8'h55);
        check("re_hold", 32'(Data_Out), 32'h55);
        for (int i = 0; i < W; i++) begin
            Ser_Valid = 1'b1;
            Ser_In    = (i % 2 == 1);
            if (i == W - 1) Data_Ready = 1'b1;
            tick();
        end
        Ser_Valid = 1'b0;
        check("re_valid", 32'(Data_Valid), 32'h1);
        check("re_data",  32'(Data_Out),   32'hAA);
        check("re_no_ovr", 32'(Overrun),   32'h0);

        // Gap timeout at exactly T idle cycles; T-1 idle cycles is tolerated.
        tick();
        send_bits(8'h96, 0, 4);
        repeat (T - 1) tick();
        check("to_busy_before", 32'(Busy),        32'h1);
        check("to_no_err_yet",  32'(Frame_Error), 32'h0);
        tick();
        check("to_error", 32'(Frame_Error), 32'h1);
        check("to_idle",  32'(Busy),        32'h0);
        tick();
        check("to_pulse_end", 32'(Frame_Error), 32'h0);
        send_bits(8'hE7, 0, 4);
        repeat (T - 1) tick();
        check("gap_ok_busy", 32'(Busy), 32'h1);
        send_bits(8'hE7, 5, 7);
        check("gap_ok_data",  32'(Data_Out),    32'hE7);
        check("gap_ok_valid", 32'(Data_Valid),  32'h1);
        check("gap_ok_noerr", 32'(Frame_Error), 32'h0);

        // Clear drops both the partial frame and the held word.
        tick();
        Data_Ready = 1'b0;
        send_word(8'h77);
        check("clr_held", 32'(Data_Out), 32'h77);
        send_bits(8'hFF, 0, 3);
        Clear     = 1'b1;
        Ser_Valid = 1'b1;
        Ser_In    = 1'b1;
        tick();
        Clear     = 1'b0;
        Ser_Valid = 1'b0;
        check("clr_valid", 32'(Data_Valid),  32'h0);
        check("clr_busy",  32'(Busy),        32'h0);
        check("clr_ferr",  32'(Frame_Error), 32'h0);
        check("clr_ovr",   32'(Overrun),     32'h0);
        check("clr_data",  32'(Data_Out),    32'h77);
        send_word(8'h0F);
        check("clr_next", 32'(Data_Out), 32'h0F);

        // Vector table: each word sent with a fixed Ready level.
        tbl[0] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[1] = '{8'hC3, 1'b0, 8'h3C, 1'b1, 1'b1};
        tbl[2] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0};
        tbl[3] = '{8'h81, 1'b0, 8'h5A, 1'b1, 1'b1};
        tbl[4] = '{8'hE7, 1'b1, 8'hE7, 1'b1, 1'b0};
        Data_Ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            Data_Ready = tbl[i].ready;
            send_word(tbl[i].word);
            check($sformatf("tbl%0d_data", i),  32'(Data_Out),   32'(tbl[i].exp_out));
            check($sformatf("tbl%0d_valid", i), 32'(Data_Valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_ovr", i),   32'(Overrun),    32'(tbl[i].exp_ovr));
        end

        // Randomized traffic with occasional long gaps and rare clears.
        gap_left = 0;
        for (int c = 0; c < 3000; c++) begin
            Clear  = ($urandom_range(0, 199) == 0);
            Ser_In = 1'($urandom_range(0, 1));
            if (gap_left > 0) begin
                Ser_Valid = 1'b0;
                gap_left--;
            end else begin
                Ser_Valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 63) == 0) gap_left = $urandom_range(12, 20);
            end
            Data_Ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
